// File: rtl/vec_mem_loader.sv
// Stream loader: header-framed segments go to the inst/data memory write ports; a start header runs the core.
// Optional VEC_LOADER_CHECKSUM_EN: each segment carries a trailing XOR checksum word.
module vec_mem_loader #(
  parameter int INST_MEM_SIZE = 256,
  parameter int DATA_MEM_SIZE = 256
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic [31:0]                      in_data,
  input  logic                             in_valid,
  output logic                             in_ready,
  output logic                             inst_we,
  output logic [$clog2(INST_MEM_SIZE)-1:0] inst_addr,
  output logic [31:0]                      inst_wdata,
  output logic                             data_we,
  output logic [$clog2(DATA_MEM_SIZE)-1:0] data_addr,
  output logic [31:0]                      data_wdata,
  output logic                             core_reset,
  input  logic                             core_done,
  output logic                             busy,
  output logic                             error,
  output logic                             run_done
);
  localparam int IAW = $clog2(INST_MEM_SIZE);
  localparam int DAW = $clog2(DATA_MEM_SIZE);
  localparam int AW  = (IAW > DAW) ? IAW : DAW;

  typedef enum logic [1:0] {HEADER, PAYLOAD, RUN, ERROR} state_t;

  state_t        state_q, state_d;
  logic          accept, wr_fire;
  logic [1:0]    hdr_type;
  logic [13:0]   hdr_base;
  logic [15:0]   hdr_cnt;
  logic [16:0]   hdr_end, hdr_lim;
  logic          hdr_ovf;
  logic [AW-1:0] ptr_q, wr_addr_q;
  logic [15:0]   rem_q;
  logic [31:0]   wr_data_q;
  logic          tgt_q, run_first_q, inst_we_q, data_we_q, run_done_q;
`ifdef VEC_LOADER_CHECKSUM_EN
  logic [31:0]   acc_q;
`endif

  assign hdr_type = in_data[31:30];
  assign hdr_base = in_data[29:16];
  assign hdr_cnt  = in_data[15:0];
  assign hdr_end  = {3'b0, hdr_base} + {1'b0, hdr_cnt};
  assign hdr_lim  = hdr_type[0] ? 17'(DATA_MEM_SIZE) : 17'(INST_MEM_SIZE);
  assign hdr_ovf  = hdr_end > hdr_lim;
  assign accept   = in_valid && in_ready;
  // rem_q == 0 in PAYLOAD only occurs while waiting for the checksum word
  assign wr_fire  = accept && (state_q == PAYLOAD) && (rem_q != 16'd0);

  always_ff @(posedge clock) begin
    if (reset) state_q <= HEADER;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      HEADER: if (accept) begin
        case (hdr_type)
          2'b10:   state_d = RUN;
          2'b11:   state_d = ERROR;
          default: if (hdr_cnt == 16'd0) state_d = HEADER;
                   else if (hdr_ovf)     state_d = ERROR;
                   else                  state_d = PAYLOAD;
        endcase
      end
      PAYLOAD: if (accept) begin
`ifdef VEC_LOADER_CHECKSUM_EN
        if (rem_q == 16'd0) state_d = (in_data == acc_q) ? HEADER : ERROR;
`else
        if (rem_q == 16'd1) state_d = HEADER;
`endif
      end
      RUN:     if (!run_first_q && core_done) state_d = HEADER;
      default: state_d = ERROR;
    endcase
  end

  // reset gates the handshake and core reset combinationally so they hold during the reset cycle
  always_comb begin
    in_ready   = !reset && (state_q == HEADER || state_q == PAYLOAD);
    core_reset = reset || (state_q != RUN);
    busy       = (state_q != HEADER);
    error      = !reset && (state_q == ERROR);
    inst_we    = inst_we_q;
    data_we    = data_we_q;
    inst_addr  = wr_addr_q[IAW-1:0];
    data_addr  = wr_addr_q[DAW-1:0];
    inst_wdata = wr_data_q;
    data_wdata = wr_data_q;
    run_done   = run_done_q;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      ptr_q       <= '0;
      rem_q       <= '0;
      tgt_q       <= 1'b0;
      run_first_q <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      inst_we_q   <= 1'b0;
      data_we_q   <= 1'b0;
      run_done_q  <= 1'b0;
`ifdef VEC_LOADER_CHECKSUM_EN
      acc_q       <= '0;
`endif
    end else begin
      inst_we_q   <= 1'b0;
      data_we_q   <= 1'b0;
      run_done_q  <= 1'b0;
      run_first_q <= 1'b0;
      if (accept && state_q == HEADER) begin
        ptr_q       <= hdr_base[AW-1:0];
        rem_q       <= hdr_cnt;
        tgt_q       <= hdr_type[0];
        run_first_q <= (hdr_type == 2'b10);
`ifdef VEC_LOADER_CHECKSUM_EN
        acc_q       <= '0;
`endif
      end
      if (wr_fire) begin
        inst_we_q <= !tgt_q;
        data_we_q <= tgt_q;
        wr_addr_q <= ptr_q;
        wr_data_q <= in_data;
        ptr_q     <= ptr_q + 1'b1;
        rem_q     <= rem_q - 16'd1;
`ifdef VEC_LOADER_CHECKSUM_EN
        acc_q     <= acc_q ^ in_data;
`endif
      end
      if (state_q == RUN && !run_first_q && core_done) run_done_q <= 1'b1;
    end
  end
endmodule

// File: tb/tb_vec_mem_loader.sv
// Directed bench for vec_mem_loader: vector table for segment loads plus hand sequences for error/run/toggle.
module tb_vec_mem_loader;
  logic        clock, reset, in_valid, in_ready, core_done, core_reset, busy, error, run_done;
  logic [31:0] in_data, inst_wdata, data_wdata;
  logic        inst_we, data_we;
  logic [7:0]  inst_addr, data_addr;

  vec_mem_loader #(.INST_MEM_SIZE(256), .DATA_MEM_SIZE(256)) dut (
    .clock(clock), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .inst_we(inst_we), .inst_addr(inst_addr), .inst_wdata(inst_wdata),
    .data_we(data_we), .data_addr(data_addr), .data_wdata(data_wdata),
    .core_reset(core_reset), .core_done(core_done), .busy(busy), .error(error), .run_done(run_done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // ctl = {in_ready, core_reset, busy, error, run_done}
  typedef struct {
    logic        rst, v;
    logic [31:0] d;
    logic [4:0]  ctl;
    logic        iwe, dwe;
    logic [7:0]  a;
    logic [31:0] wd;
  } vec_t;

  localparam logic [4:0] HDR = 5'b11000, PAY = 5'b11100, RST = 5'b01000;
`ifdef VEC_LOADER_CHECKSUM_EN
  localparam logic [4:0] LAST = PAY;
`else
  localparam logic [4:0] LAST = HDR;
`endif
  localparam logic [31:0] WA = 32'hA5A5_0001, WB = 32'h5A5A_0002, WC = 32'hDEAD_BEEF;

  vec_t tbl[$];
  int   errors = 0, checks = 0;

  function automatic void add(logic rst, logic v, logic [31:0] d, logic [4:0] ctl,
                              logic iwe, logic dwe, logic [7:0] a, logic [31:0] wd);
    vec_t t;
    t.rst = rst; t.v = v; t.d = d; t.ctl = ctl; t.iwe = iwe; t.dwe = dwe; t.a = a; t.wd = wd;
    tbl.push_back(t);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1; in_valid = 1'b0; core_done = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
  endtask

  task automatic send(input logic [31:0] d);
    in_valid = 1'b1; in_data = d;
    @(negedge clock);
    in_valid = 1'b0;
  endtask

  logic [7:0]  wa[$];
  logic [31:0] wdq[$];
  int          bad;
  logic [46:0] act, exp;

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_data = '0; core_done = 1'b0;
    @(negedge clock); @(negedge clock);
    chk("reset_regs", {inst_addr, inst_wdata, data_addr, data_wdata, inst_we, data_we, run_done}, '0);

    add(1, 0, 32'h0,         RST,  0, 0, 8'd0,   32'h0);
    add(0, 1, 32'h0000_0003, PAY,  0, 0, 8'd0,   32'h0);
    add(0, 1, WA,            PAY,  1, 0, 8'd0,   WA);
    add(0, 1, WB,            PAY,  1, 0, 8'd1,   WB);
    add(0, 1, WC,            LAST, 1, 0, 8'd2,   WC);
`ifdef VEC_LOADER_CHECKSUM_EN
    add(0, 1, WA ^ WB ^ WC,  HDR,  0, 0, 8'd0,   32'h0);
`endif
    add(0, 0, 32'hFFFF_FFFF, HDR,  0, 0, 8'd0,   32'h0);
    add(0, 1, 32'h0005_0000, HDR,  0, 0, 8'd0,   32'h0);
    add(0, 1, 32'h4010_0002, PAY,  0, 0, 8'd0,   32'h0);
    add(0, 1, 32'h11,        PAY,  0, 1, 8'd16,  32'h11);
    add(0, 1, 32'h22,        LAST, 0, 1, 8'd17,  32'h22);
`ifdef VEC_LOADER_CHECKSUM_EN
    add(0, 1, 32'h33,        HDR,  0, 0, 8'd0,   32'h0);
`endif
    add(0, 1, 32'h40FF_0001, PAY,  0, 0, 8'd0,   32'h0);
    add(0, 1, 32'h0BAD_F00D, LAST, 0, 1, 8'd255, 32'h0BAD_F00D);
`ifdef VEC_LOADER_CHECKSUM_EN
    add(0, 1, 32'h0BAD_F00D, HDR,  0, 0, 8'd0,   32'h0);
`endif
    add(0, 1, 32'h4020_0005, PAY,  0, 0, 8'd0,   32'h0);
    add(0, 1, 32'h100,       PAY,  0, 1, 8'd32,  32'h100);
    add(0, 1, 32'h101,       PAY,  0, 1, 8'd33,  32'h101);
    add(1, 1, 32'h102,       RST,  0, 0, 8'd0,   32'h0);
    add(0, 0, 32'h103,       HDR,  0, 0, 8'd0,   32'h0);
    add(0, 1, 32'h0000_0001, PAY,  0, 0, 8'd0,   32'h0);
    add(0, 1, 32'h77,        LAST, 1, 0, 8'd0,   32'h77);
`ifdef VEC_LOADER_CHECKSUM_EN
    add(0, 1, 32'h77,        HDR,  0, 0, 8'd0,   32'h0);
`endif

    foreach (tbl[i]) begin
      reset = tbl[i].rst; in_valid = tbl[i].v; in_data = tbl[i].d;
      @(negedge clock);
      act = {in_ready, core_reset, busy, error, run_done, inst_we, data_we,
             inst_we ? inst_addr : (data_we ? data_addr : 8'd0),
             inst_we ? inst_wdata : (data_we ? data_wdata : 32'd0)};
      exp = {tbl[i].ctl, tbl[i].iwe, tbl[i].dwe, tbl[i].a, tbl[i].wd};
      chk($sformatf("vec%0d", i), 64'(act), 64'(exp));
    end
    in_valid = 1'b0; reset = 1'b0;
    @(negedge clock);

    // data segment overflowing the memory: sticky error, nothing written
    send(32'h40FE_0004);
    chk("ovf_enter", {in_ready, error, busy, core_reset, data_we, inst_we}, 6'b011100);
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_data = 32'h40 + i;
      @(negedge clock);
      if (data_we || inst_we) bad++;
    end
    in_valid = 1'b0;
    chk("ovf_nowrite", bad, 0);
    chk("ovf_sticky", {in_ready, error, core_reset}, 3'b011);
    do_reset();
    chk("ovf_cleared", {in_ready, error, busy}, 3'b100);
    send(32'h00FD_0004);
    chk("inst_ovf", {error, inst_we}, 2'b10);
    do_reset();
    send(32'hC000_0000);
    chk("reserved_type", {error, in_ready}, 2'b10);
    do_reset();

    // run: core_done in the first RUN cycle is ignored
    send(32'h8000_0000);
    chk("run_enter", {in_ready, core_reset, busy, run_done}, 4'b0010);
    core_done = 1'b1;
    @(negedge clock);
    core_done = 1'b0;
    chk("run_first_ignored", {core_reset, busy, run_done}, 3'b010);
    bad = 0;
    for (int i = 0; i < 19; i++) begin
      @(negedge clock);
      if (core_reset || run_done || in_ready || !busy) bad++;
    end
    chk("run_hold", bad, 0);
    core_done = 1'b1;
    @(negedge clock);
    core_done = 1'b0;
    chk("run_done", {run_done, core_reset, busy, in_ready}, 4'b1101);
    @(negedge clock);
    chk("run_done_pulse", {run_done, core_reset, busy}, 3'b010);

    // reset in the middle of a run
    send(32'h8000_0000);
    repeat (3) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    chk("run_abort", {core_reset, run_done, in_ready}, 3'b100);
    reset = 1'b0;
    @(negedge clock);
    chk("run_abort_after", {core_reset, busy, run_done, in_ready}, 4'b1001);

    // data segment with in_valid toggling; idle data looks like a reserved header
    send(32'h4064_0002);
    wa.delete(); wdq.delete();
    for (int i = 0; i < 8; i++) begin
`ifdef VEC_LOADER_CHECKSUM_EN
      in_valid = (i == 1 || i == 3 || i == 5);
`else
      in_valid = (i == 1 || i == 3);
`endif
      in_data = (i == 5) ? 32'h2 : 32'hC0DE_0000 + i;
      @(negedge clock);
      if (data_we) begin wa.push_back(data_addr); wdq.push_back(data_wdata); end
      if (inst_we) begin wa.push_back(8'hEE); wdq.push_back(32'hEEEE_EEEE); end
    end
    in_valid = 1'b0;
    chk("toggle_count", wa.size(), 2);
    if (wa.size() == 2) begin
      chk("toggle_w0", {wa[0], wdq[0]}, {8'd100, 32'hC0DE_0001});
      chk("toggle_w1", {wa[1], wdq[1]}, {8'd101, 32'hC0DE_0003});
    end
    chk("toggle_end", {busy, error, in_ready}, 3'b001);

`ifdef VEC_LOADER_CHECKSUM_EN
    bad = 0;
    send(32'h4000_0002);
    send(32'h1); if (data_we) bad++;
    send(32'h3); if (data_we) bad++;
    send(32'h3);
    chk("csum_bad_writes", bad, 2);
    chk("csum_bad_err", {error, in_ready}, 2'b10);
    do_reset();
    send(32'h4000_0002);
    send(32'h1);
    send(32'h3);
    send(32'h2);
    chk("csum_ok", {error, busy, in_ready}, 3'b001);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
